cache_line_mover: RTL and testbench

Parametrised line-transfer engine between the cache data RAM and main memory. It supports write-back (cache to memory), refill (memory to cache), and a combined write-back-then-refill for dirty misses. Main-memory accesses use a req/ready handshake, so memory may insert wait states. Sits between the cache controller FSM and the main-memory port.

---
 rtl/cache_line_mover_pkg.sv | 26 ++
 rtl/cache_line_mover.sv | 191 +++++++++++++++++++
 tb/tb_cache_line_mover.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_line_mover_pkg.sv
// -----------------------------------------------------------------------------
// cache_line_mover_pkg
// Shared definitions for the cache line transfer engine: operation encodings
// presented on the 'op' port and the controller state encoding.
// -----------------------------------------------------------------------------
package cache_line_mover_pkg;

    // Operation codes. Bit 0 requests a write-back of the victim line,
    // bit 1 requests a refill of the new line; both together run the
    // write-back first and then the refill.
    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_WB   = 2'b01;
    localparam logic [1:0] OP_RF   = 2'b10;
    localparam logic [1:0] OP_WBRF = 2'b11;

    // Controller states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WB_RD  = 3'd1,
        WB_WR  = 3'd2,
        RF_REQ = 3'd3,
        RF_WR  = 3'd4,
        DONE   = 3'd5
    } state_t;

endpackage

// File: rtl/cache_line_mover.sv
// -----------------------------------------------------------------------------
// cache_line_mover
// Moves one cache line between the cache data RAM and main memory. Supports
// write-back (cache -> memory), refill (memory -> cache) and write-back
// followed by refill for dirty misses. Main-memory accesses use a req/ready
// handshake so memory may stall any request for any number of cycles.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active low
//   start        begin an operation (only looked at while idle)
//   op           01 write-back, 10 refill, 11 write-back then refill
//   wb_addr      byte address of the victim line
//   rf_addr      byte address of the line to fetch
//   busy         high whenever the engine is not idle
//   done         single-cycle completion pulse
//   mem_req      memory request valid
//   mem_we       1 = write, 0 = read
//   mem_addr     memory word address
//   mem_wdata    memory write data
//   mem_ready    request accepted; read data valid in the same cycle
//   mem_rdata    memory read data
//   cache_addr   cache data RAM word address {index, word}
//   cache_we     cache write enable
//   cache_wdata  cache write data
//   cache_rdata  cache read data, one cycle after cache_addr
// -----------------------------------------------------------------------------
module cache_line_mover
    import cache_line_mover_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int WORDS_PER_LINE = 8,
    parameter int INDEX_W        = 6,
    parameter int MEM_ADDR_W     = 10,
    localparam int OFFSET_W      = $clog2(WORDS_PER_LINE)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [1:0]                  op,
    input  logic [ADDR_W-1:0]           wb_addr,
    input  logic [ADDR_W-1:0]           rf_addr,
    output logic                        busy,
    output logic                        done,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [MEM_ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic                        mem_ready,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic [INDEX_W+OFFSET_W-1:0] cache_addr,
    output logic                        cache_we,
    output logic [DATA_W-1:0]           cache_wdata,
    input  logic [DATA_W-1:0]           cache_rdata
);

    localparam int LINE_SHIFT = OFFSET_W + 2;
    localparam logic [OFFSET_W-1:0] LAST_WORD = OFFSET_W'(WORDS_PER_LINE - 1);

    state_t                state;
    state_t                next_state;
    logic [OFFSET_W-1:0]   word_cnt;
    logic [ADDR_W-1:0]     wb_line;
    logic [ADDR_W-1:0]     rf_line;
    logic                  do_refill;
    logic [DATA_W-1:0]     wb_data;
    logic                  wb_data_held;
    logic [DATA_W-1:0]     rf_data;

    logic                  accept;
    logic                  last_word;
    logic [INDEX_W-1:0]    wb_index;
    logic [INDEX_W-1:0]    rf_index;
    logic [MEM_ADDR_W-1:0] wb_mem_addr;
    logic [MEM_ADDR_W-1:0] rf_mem_addr;

    assign accept    = (state == IDLE) && start && (op != OP_NONE);
    assign last_word = (word_cnt == LAST_WORD);

    // Strip the byte and word offset, then keep the set index for the cache
    // side and splice the word counter under the line number for memory.
    assign wb_index    = INDEX_W'(wb_line >> LINE_SHIFT);
    assign rf_index    = INDEX_W'(rf_line >> LINE_SHIFT);
    assign wb_mem_addr = MEM_ADDR_W'((wb_line >> LINE_SHIFT) << OFFSET_W) | MEM_ADDR_W'(word_cnt);
    assign rf_mem_addr = MEM_ADDR_W'((rf_line >> LINE_SHIFT) << OFFSET_W) | MEM_ADDR_W'(word_cnt);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and Moore output decode. During WB_WR the RAM output is only
    // guaranteed valid in the first cycle (cache_addr returns to 0 after
    // WB_RD), so a stalled write switches over to the captured copy.
    always_comb begin
        next_state  = state;
        busy        = 1'b1;
        done        = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        cache_addr  = '0;
        cache_we    = 1'b0;
        cache_wdata = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (accept) begin
                    next_state = op[0] ? WB_RD : RF_REQ;
                end
            end
            WB_RD: begin
                cache_addr = {wb_index, word_cnt};
                next_state = WB_WR;
            end
            WB_WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = wb_mem_addr;
                mem_wdata = wb_data_held ? wb_data : cache_rdata;
                if (mem_ready) begin
                    if (!last_word) begin
                        next_state = WB_RD;
                    end else begin
                        next_state = do_refill ? RF_REQ : DONE;
                    end
                end
            end
            RF_REQ: begin
                mem_req  = 1'b1;
                mem_addr = rf_mem_addr;
                if (mem_ready) begin
                    next_state = RF_WR;
                end
            end
            RF_WR: begin
                cache_we    = 1'b1;
                cache_addr  = {rf_index, word_cnt};
                cache_wdata = rf_data;
                next_state  = last_word ? DONE : RF_REQ;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                busy       = 1'b0;
                next_state = IDLE;
            end
        endcase
    end

    // Address/op latches, word counter and data holding registers. The
    // counter simply increments after each word; the last word rolls it back
    // to zero ready for the next phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_cnt     <= '0;
            wb_line      <= '0;
            rf_line      <= '0;
            do_refill    <= 1'b0;
            wb_data      <= '0;
            wb_data_held <= 1'b0;
            rf_data      <= '0;
        end else begin
            if (accept) begin
                wb_line   <= wb_addr;
                rf_line   <= rf_addr;
                do_refill <= op[1];
                word_cnt  <= '0;
            end
            if ((state == WB_WR) && !wb_data_held) begin
                wb_data <= cache_rdata;
            end
            wb_data_held <= (state == WB_WR) && !mem_ready;
            if (((state == WB_WR) && mem_ready) || (state == RF_WR)) begin
                word_cnt <= word_cnt + OFFSET_W'(1);
            end
            if ((state == RF_REQ) && mem_ready) begin
                rf_data <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_cache_line_mover.sv
// -----------------------------------------------------------------------------
// tb_cache_line_mover
// Self-checking bench for cache_line_mover. Models a synchronous cache data
// RAM and a main memory with programmable wait states, drives directed and
// random line operations, and compares every memory transaction, cache write,
// cache read address, final memory/cache contents and latency against a
// reference computed from whole-line transfers.
// -----------------------------------------------------------------------------
module tb_cache_line_mover;
    import cache_line_mover_pkg::*;

    localparam int WPL         = 8;
    localparam int CACHE_WORDS = 512;
    localparam int MEM_WORDS   = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] wb_addr;
    logic [31:0] rf_addr;
    logic        busy;
    logic        done;
    logic        mem_req;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [8:0]  cache_addr;
    logic        cache_we;
    logic [31:0] cache_wdata;
    logic [31:0] cache_rdata;

    logic [31:0] mem_arr   [0:MEM_WORDS-1];
    logic [31:0] cache_arr [0:CACHE_WORDS-1];

    logic        bd_fill     = 1'b0;
    logic        bd_mem_we   = 1'b0;
    logic        bd_cache_we = 1'b0;
    logic [9:0]  bd_addr     = '0;
    logic [31:0] bd_data     = '0;

    int ws        = 0;
    int stall_cnt = 0;

    logic [63:0] txn_q [$];
    logic [63:0] cw_q  [$];
    logic [8:0]  rd_q  [$];
    int          done_seen = 0;

    int pass_cnt  = 0;
    int check_cnt = 0;
    int fail_cnt  = 0;

    cache_line_mover dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .wb_addr     (wb_addr),
        .rf_addr     (rf_addr),
        .busy        (busy),
        .done        (done),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .cache_addr  (cache_addr),
        .cache_we    (cache_we),
        .cache_wdata (cache_wdata),
        .cache_rdata (cache_rdata)
    );

    always #5 clk = ~clk;

    // Cache RAM (synchronous read) and main memory (combinational read),
    // plus a backdoor used to preload contents.
    always @(posedge clk) begin
        if (bd_fill) begin
            for (int i = 0; i < MEM_WORDS; i++) mem_arr[i] <= $urandom;
            for (int i = 0; i < CACHE_WORDS; i++) cache_arr[i] <= $urandom;
        end
        if (bd_mem_we) mem_arr[bd_addr] <= bd_data;
        if (bd_cache_we) cache_arr[bd_addr[8:0]] <= bd_data;
        if (mem_req && mem_ready && mem_we) mem_arr[mem_addr] <= mem_wdata;
        if (cache_we) cache_arr[cache_addr] <= cache_wdata;
        cache_rdata <= cache_arr[cache_addr];
    end

    assign mem_rdata = mem_arr[mem_addr];

    // Memory holds off every request for 'ws' cycles before accepting it.
    assign mem_ready = mem_req && (stall_cnt == ws);

    always @(posedge clk) begin
        if (mem_req && !mem_ready) stall_cnt <= stall_cnt + 1;
        else stall_cnt <= 0;
    end

    // Transaction logger. Cache reads are the cycles with neither a memory
    // request, a cache write nor done while busy.
    always @(negedge clk) begin
        if (mem_req && mem_ready) txn_q.push_back({21'd0, mem_we, mem_addr, mem_we ? mem_wdata : mem_rdata});
        if (cache_we) cw_q.push_back({23'd0, cache_addr, cache_wdata});
        if (busy && !cache_we && !mem_req && !done) rd_q.push_back(cache_addr);
        if (done) done_seen++;
    end

    function automatic logic [63:0] outsMem();
        return {18'd0, busy, done, mem_req, mem_we, mem_addr, mem_wdata};
    endfunction

    function automatic logic [63:0] outsCache();
        return {22'd0, cache_addr, cache_we, cache_wdata};
    endfunction

    // Reference mapping: line number = byte address / 32 bytes per line.
    function automatic int memWord(input logic [31:0] a, input int k);
        return int'(((a / 32) * 8 + 32'(k)) % 1024);
    endfunction

    function automatic int cacheWord(input logic [31:0] a, input int k);
        return int'(((a / 32) % 64) * 8 + 32'(k));
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_cnt++;
        assert (observed === expected) pass_cnt++;
        else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic backdoorWrite(input logic to_cache, input int a, input logic [31:0] d);
        @(negedge clk);
        bd_addr     = 10'(a);
        bd_data     = d;
        bd_mem_we   = !to_cache;
        bd_cache_we = to_cache;
        @(negedge clk);
        bd_mem_we   = 1'b0;
        bd_cache_we = 1'b0;
    endtask

    // Runs one operation to completion with random interfering starts and
    // input changes, then checks it against the whole-line reference.
    task automatic applyStimulus(input logic [1:0] op_sel, input logic [31:0] wb, input logic [31:0] rf,
                                 input int wait_cycles, output int lat);
        logic [31:0] mem_model   [0:MEM_WORDS-1];
        logic [31:0] cache_model [0:CACHE_WORDS-1];
        logic [63:0] exp_q  [$];
        logic [63:0] exp_cw [$];
        logic [8:0]  exp_rd [$];
        logic [63:0] prev_bus;
        logic        prev_stall;
        int txn_base, cw_base, rd_base, done_base, exp_lat, busy_drops, wr_reqs, diffs, a, c;
        logic [31:0] d;

        mem_model   = mem_arr;
        cache_model = cache_arr;
        if (op_sel[0]) begin
            for (int k = 0; k < WPL; k++) begin
                a = memWord(wb, k);
                c = cacheWord(wb, k);
                d = cache_model[c];
                mem_model[a] = d;
                exp_q.push_back({21'd0, 1'b1, 10'(a), d});
                exp_rd.push_back(9'(c));
            end
        end
        if (op_sel[1]) begin
            for (int k = 0; k < WPL; k++) begin
                a = memWord(rf, k);
                c = cacheWord(rf, k);
                d = mem_model[a];
                cache_model[c] = d;
                exp_q.push_back({21'd0, 1'b0, 10'(a), d});
                exp_cw.push_back({23'd0, 9'(c), d});
            end
        end
        exp_lat = (int'(op_sel[0]) + int'(op_sel[1])) * WPL * (2 + wait_cycles);

        txn_base  = txn_q.size();
        cw_base   = cw_q.size();
        rd_base   = rd_q.size();
        done_base = done_seen;
        ws        = wait_cycles;

        @(negedge clk);
        start   = 1'b1;
        op      = op_sel;
        wb_addr = wb;
        rf_addr = rf;
        @(posedge clk);

        lat        = -1;
        busy_drops = 0;
        wr_reqs    = 0;
        prev_stall = 1'b0;
        prev_bus   = '0;
        for (int n = 0; n < exp_lat + 64; n++) begin
            @(negedge clk);
            if (done) begin
                lat = n;
                break;
            end
            if (!busy) busy_drops++;
            if (mem_req && mem_we) wr_reqs++;
            if (prev_stall && mem_req)
                checkOutput("stall_hold", {21'd0, mem_we, mem_addr, mem_wdata}, prev_bus);
            prev_stall = mem_req && !mem_ready;
            prev_bus   = {21'd0, mem_we, mem_addr, mem_wdata};
            start   = ($urandom_range(0, 3) == 0);
            op      = 2'($urandom);
            wb_addr = $urandom;
            rf_addr = $urandom;
        end

        // A start presented while in DONE must be ignored.
        start = 1'b1;
        op    = OP_WBRF;
        @(negedge clk);
        start = 1'b0;

        checkOutput("latency", 64'(lat), 64'(exp_lat));
        checkOutput("done_then_idle", {62'd0, done, busy}, 64'd0);
        checkOutput("done_count", 64'(done_seen - done_base), 64'd1);
        checkOutput("busy_hold", 64'(busy_drops), 64'd0);
        if (!op_sel[0]) checkOutput("rf_no_mem_write", 64'(wr_reqs), 64'd0);

        checkOutput("txn_count", 64'(txn_q.size() - txn_base), 64'(exp_q.size()));
        foreach (exp_q[i])
            if (txn_base + i < txn_q.size()) checkOutput($sformatf("txn%0d", i), txn_q[txn_base + i], exp_q[i]);
        checkOutput("cache_wr_count", 64'(cw_q.size() - cw_base), 64'(exp_cw.size()));
        foreach (exp_cw[i])
            if (cw_base + i < cw_q.size()) checkOutput($sformatf("cache_wr%0d", i), cw_q[cw_base + i], exp_cw[i]);
        checkOutput("cache_rd_count", 64'(rd_q.size() - rd_base), 64'(exp_rd.size()));
        foreach (exp_rd[i])
            if (rd_base + i < rd_q.size()) checkOutput($sformatf("cache_rd%0d", i), 64'(rd_q[rd_base + i]), 64'(exp_rd[i]));

        diffs = 0;
        for (int i = 0; i < MEM_WORDS; i++) if (mem_arr[i] !== mem_model[i]) diffs++;
        checkOutput("mem_contents", 64'(diffs), 64'd0);
        diffs = 0;
        for (int i = 0; i < CACHE_WORDS; i++) if (cache_arr[i] !== cache_model[i]) diffs++;
        checkOutput("cache_contents", 64'(diffs), 64'd0);
    endtask

    initial begin
        int lat;
        int done_base;
        int txn_base;
        int busy_seen;
        logic found;
        logic [1:0] rop;

        rst     = 1'b0;
        start   = 1'b0;
        op      = OP_NONE;
        wb_addr = '0;
        rf_addr = '0;

        #1;
        checkOutput("reset_mem_side", outsMem(), 64'd0);
        checkOutput("reset_cache_side", outsCache(), 64'd0);

        bd_fill = 1'b1;
        @(posedge clk);
        #1 bd_fill = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Write-back of line 0x1A40 with known cache contents.
        $display("[TB] write-back 0x1A40");
        for (int i = 0; i < WPL; i++) begin
            backdoorWrite(1'b1, 144 + i, 32'hA0 + 32'(i));
            backdoorWrite(1'b0, 656 + i, 32'h0);
        end
        applyStimulus(OP_WB, 32'h0000_1A40, $urandom, 0, lat);
        checkOutput("wb_latency_16", 64'(lat), 64'd16);
        for (int i = 0; i < WPL; i++)
            checkOutput($sformatf("wb_mem%0d", i), 64'(mem_arr[656 + i]), 64'(32'hA0 + 32'(i)));

        // Refill of line 0x20 from known memory contents.
        $display("[TB] refill 0x20");
        for (int j = 0; j < WPL; j++) backdoorWrite(1'b0, 8 + j, 32'hB000 + 32'(j));
        applyStimulus(OP_RF, $urandom, 32'h0000_0020, 0, lat);
        checkOutput("rf_latency_16", 64'(lat), 64'd16);
        for (int j = 0; j < WPL; j++)
            checkOutput($sformatf("rf_cache%0d", j), 64'(cache_arr[8 + j]), 64'(32'hB000 + 32'(j)));

        // Write-back then refill.
        $display("[TB] write-back then refill");
        for (int j = 0; j < WPL; j++) backdoorWrite(1'b0, 8 + j, 32'hC000 + 32'(j));
        applyStimulus(OP_WBRF, 32'h0000_1A40, 32'h0000_0020, 0, lat);
        checkOutput("wbrf_latency_32", 64'(lat), 64'd32);

        // Three wait states on every request.
        $display("[TB] wait states");
        applyStimulus(OP_WB, 32'h0000_1A40, $urandom, 3, lat);
        checkOutput("ws_latency_40", 64'(lat), 64'd40);

        // op=00 start is ignored.
        $display("[TB] op 00 start");
        txn_base  = txn_q.size();
        done_base = done_seen;
        busy_seen = 0;
        ws = 0;
        @(negedge clk);
        start = 1'b1;
        op    = OP_NONE;
        repeat (4) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_seen++;
        end
        checkOutput("op00_busy", 64'(busy_seen), 64'd0);
        checkOutput("op00_done", 64'(done_seen - done_base), 64'd0);
        checkOutput("op00_txn", 64'(txn_q.size() - txn_base), 64'd0);

        // Asynchronous reset at word 3 of a write-back.
        $display("[TB] reset mid write-back");
        @(negedge clk);
        start   = 1'b1;
        op      = OP_WB;
        wb_addr = 32'h0000_1A40;
        rf_addr = '0;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 64; n++) begin
            if (mem_req && mem_we && (mem_addr == 10'h293)) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("rst_reach_word3", 64'(found), 64'd1);
        done_base = done_seen;
        rst = 1'b0;
        #1;
        checkOutput("rst_async_mem", outsMem(), 64'd0);
        checkOutput("rst_async_cache", outsCache(), 64'd0);
        repeat (3) @(negedge clk);
        checkOutput("rst_no_done", 64'(done_seen - done_base), 64'd0);
        rst = 1'b1;

        $display("[TB] write-back after reset");
        for (int i = 0; i < WPL; i++) backdoorWrite(1'b0, 656 + i, 32'h0);
        applyStimulus(OP_WB, 32'h0000_1A40, $urandom, 0, lat);
        checkOutput("wb2_latency_16", 64'(lat), 64'd16);
        for (int i = 0; i < WPL; i++)
            checkOutput($sformatf("wb2_mem%0d", i), 64'(mem_arr[656 + i]), 64'(32'hA0 + 32'(i)));

        // Random operations, addresses and wait states.
        $display("[TB] random operations");
        for (int t = 0; t < 24; t++) begin
            rop = 2'($urandom_range(1, 3));
            applyStimulus(rop, $urandom, $urandom, $urandom_range(0, 2), lat);
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
